// File: rtl/fpu_req_ctrl.sv
// rtl/fpu_req_ctrl.sv - bf16 FPU initiator: request handshake, multicycle exec hold, response handshake.
// Optional macro FPU_REQ_CTRL_NANBOX_EN forces resp_result_o[15:0]=16'hFFFF for FP-destination results.
package ibex_pkg;
    typedef enum logic [3:0] {
        FP_ALU_ADD    = 4'd0,
        FP_ALU_SUB    = 4'd1,
        FP_ALU_MUL    = 4'd2,
        FP_ALU_MINMAX = 4'd3,
        FP_ALU_SGNJ   = 4'd4,
        FP_ALU_CMP    = 4'd5,
        FP_ALU_CLASS  = 4'd6,
        FP_ALU_CVT    = 4'd7
    } fp_alu_op_e;
endpackage

module fpu_req_ctrl
    import ibex_pkg::*;
#(
    parameter int unsigned ExecCycles = 1,
    parameter int unsigned CntWidth   = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  fp_alu_op_e          req_op_i,
    input  logic [1:0]          req_mode_i,
    input  logic [31:0]         req_a_i,
    input  logic [15:0]         req_b_i,
    input  logic [4:0]          req_rd_i,
    input  logic                flush_i,
    output fp_alu_op_e          fpu_operator_o,
    output logic [31:0]         fpu_operand_a_o,
    output logic [15:0]         fpu_operand_b_o,
    output logic [1:0]          fpu_mode_o,
    input  logic [31:0]         fpu_result_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [31:0]         resp_result_o,
    output logic [4:0]          resp_rd_o,
    output logic                resp_dest_fp_o,
    output logic                busy_o,
    output logic [CntWidth-1:0] op_count_o
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    localparam logic [3:0] CntLoad = 4'(ExecCycles - 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q;
    fp_alu_op_e          op_q;
    logic [1:0]          mode_q;
    logic [31:0]         a_q;
    logic [15:0]         b_q;
    logic [4:0]          rd_q;
    logic                dest_fp_q;
    logic [31:0]         result_q;
    logic [4:0]          resp_rd_q;
    logic                resp_dest_fp_q;
    logic [CntWidth-1:0] count_q;
    logic                accept, handshake, capture, req_dest_fp;
    logic [31:0]         captured;

    always_comb begin
        req_dest_fp = 1'b0;
        case (req_op_i)
            FP_ALU_ADD, FP_ALU_SUB, FP_ALU_MUL,
            FP_ALU_MINMAX, FP_ALU_SGNJ: req_dest_fp = 1'b1;
            FP_ALU_CVT:                 req_dest_fp = req_mode_i[1];
            default:                    req_dest_fp = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        capture      = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = !flush_i;
                if (req_valid_i && !flush_i) state_d = EXEC;
            end
            EXEC: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (resp_ready_i) begin
                    // Back-to-back: the freed response slot may take a new request this cycle.
                    req_ready_o = 1'b1;
                    state_d     = req_valid_i ? EXEC : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst_i) req_ready_o = 1'b0;
    end

    assign accept    = req_valid_i && req_ready_o;
    assign handshake = resp_valid_o && resp_ready_i && !flush_i;

`ifdef FPU_REQ_CTRL_NANBOX_EN
    assign captured = dest_fp_q ? {fpu_result_i[31:16], 16'hFFFF} : fpu_result_i;
`else
    assign captured = fpu_result_i;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            op_q           <= FP_ALU_ADD;
            mode_q         <= 2'b00;
            a_q            <= 32'd0;
            b_q            <= 16'd0;
            rd_q           <= 5'd0;
            dest_fp_q      <= 1'b0;
            result_q       <= 32'd0;
            resp_rd_q      <= 5'd0;
            resp_dest_fp_q <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= req_op_i;
                mode_q    <= req_mode_i;
                a_q       <= req_a_i;
                b_q       <= req_b_i;
                rd_q      <= req_rd_i;
                dest_fp_q <= req_dest_fp;
                cnt_q     <= CntLoad;
            end else if (state_q == EXEC && cnt_q != 4'd0) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (capture) begin
                result_q       <= captured;
                resp_rd_q      <= rd_q;
                resp_dest_fp_q <= dest_fp_q;
            end
            if (handshake) count_q <= count_q + {{(CntWidth-1){1'b0}}, 1'b1};
        end
    end

    assign fpu_operator_o  = op_q;
    assign fpu_operand_a_o = a_q;
    assign fpu_operand_b_o = b_q;
    assign fpu_mode_o      = mode_q;
    assign resp_result_o   = result_q;
    assign resp_rd_o       = resp_rd_q;
    assign resp_dest_fp_o  = resp_dest_fp_q;
    assign busy_o          = (state_q != IDLE);
    assign op_count_o      = count_q;

endmodule

// File: doc/fpu_req_ctrl.md
Name: fpu_req_ctrl

Overview:
- Initiator side of the bfloat16 FPU operation interface.
- Accepts decoded FP instructions from the Ibex ID/EX stage over a valid/ready handshake and registers the operands.
- Drives operator, operands and mode into the combinational FPU, waits a configurable number of cycles for multicycle-path timing, then captures the result.
- Returns the result with its destination tag over a second valid/ready handshake toward writeback.

Parameters:
- ExecCycles, 1, cycles the FPU inputs are held stable before the result is sampled (1..15).
- CntWidth, 32, width of the completed-operation counter.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  synchronous active-high reset
- req_valid_i  input  1  request valid
- req_ready_o  output  1  request accepted when valid and ready are both high
- req_op_i  input  ibex_pkg::fp_alu_op_e  FPU operator
- req_mode_i  input  2  FPU mode field
- req_a_i  input  32  operand A; bf16 in [31:16], full word for int-to-fp convert
- req_b_i  input  16  operand B, bf16
- req_rd_i  input  5  destination register index
- flush_i  input  1  abort any in-flight operation
- fpu_operator_o  output  ibex_pkg::fp_alu_op_e  to FPU operator input
- fpu_operand_a_o  output  32  to FPU operand A
- fpu_operand_b_o  output  16  to FPU operand B
- fpu_mode_o  output  2  to FPU mode
- fpu_result_i  input  32  FPU result
- resp_valid_o  output  1  response valid
- resp_ready_i  input  1  response consumed
- resp_result_o  output  32  captured result
- resp_rd_o  output  5  destination index
- resp_dest_fp_o  output  1  1 = FP register file, 0 = integer register file
- busy_o  output  1  state is not IDLE
- op_count_o  output  CntWidth  completed (handshaken) responses, wraps modulo 2^CntWidth

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is synchronous and active-high.
- Reset values:
  - State goes to IDLE.
  - All registered outputs are 0: fpu_* outputs, resp_*, op_count_o.
  - Operator register resets to FP_ALU_ADD; mode to 2'b00.
  - req_ready_o = 0 while rst_i is high.
- States:
  - IDLE: req_ready_o=1. On accept, latch op, mode, a, b, rd and the computed dest_fp. Load counter with ExecCycles-1. Go to EXEC.
  - EXEC: fpu_* outputs driven from the latched registers, stable for ExecCycles cycles. When the counter reaches 0, register fpu_result_i into resp_result_o and go to RESP. Otherwise decrement.
  - RESP: resp_valid_o=1; all resp_* outputs held stable until resp_ready_i.
    - On handshake, op_count_o increments.
    - req_ready_o = resp_ready_i in this state. A simultaneous accept goes directly to EXEC with the new request latched (back-to-back).
    - Handshake without a new request goes to IDLE.
- Latency: accept at edge N; resp_valid_o high from edge N+ExecCycles+1. Throughput is one op per ExecCycles+1 cycles with resp_ready_i held high.
- dest_fp is 1 for ADD, SUB, MUL, MINMAX, SGNJ, and for CVT with mode[1]=1. It is 0 for CMP, CLASS, and CVT with mode[1]=0. Unknown ops give dest_fp=0.
- fpu_operand_b_o is passed unmodified. Sign inversion for SUB is done inside the FPU, not here.
- Flush:
  - flush_i in EXEC or RESP returns to IDLE next cycle. resp_valid_o drops; op_count_o is unchanged.
  - flush_i has priority over a same-cycle accept or response handshake: no request is accepted and no count is taken.
  - flush_i in IDLE has no effect, and req_ready_o is forced to 0 that cycle.
- Reset mid-operation discards all latched state. No response is produced.
- A request arriving while not ready is held by the sender. Inputs are not sampled.

Optional Feature:
- Macro: FPU_REQ_CTRL_NANBOX_EN.
- Defined: for dest_fp=1 responses, resp_result_o[15:0] is forced to 16'hFFFF (NaN-boxing the bf16 in [31:16]). Integer-destination results pass unmodified.
- Undefined: resp_result_o equals the captured fpu_result_i exactly.

Test Plan:
- ExecCycles=1, ADD, a=0x3F80_0000 (1.0), b=0x4000 (2.0), rd=5, resp_ready_i=1 -> resp_valid_o high at accept+2 cycles with resp_result_o=0x4040_0000 (0x4040_FFFF with NaN-boxing enabled), rd=5, dest_fp=1, op_count_o=1.
- CMP mode=2'b01 (less-than), a=0x3F80_0000, b=0x4000 -> resp_result_o=0x0000_0001, dest_fp=0. CVT mode=2'b00, a=0x4040_0000 -> result=3, dest_fp=0.
- Backpressure: resp_ready_i=0 for 5 cycles -> resp_valid_o and resp_result_o held stable, req_ready_o=0. Release resp_ready_i with a new request pending -> both handshakes occur the same cycle and the next response follows ExecCycles+1 later.
- ExecCycles=3 -> fpu_operand_*_o stable for exactly 3 cycles, busy_o high for 4 cycles; MUL 0x4000*0x4040 returns 0x40C0.
- flush_i asserted in EXEC, then in RESP together with resp_ready_i=1 -> state returns to IDLE, no resp_valid_o, op_count_o unchanged. flush_i in IDLE with req_valid_i=1 -> not accepted.
- rst_i asserted during RESP -> next cycle resp_valid_o=0, op_count_o=0, busy_o=0; req_ready_o=1 the cycle after rst_i deasserts.
